// File: rtl/uart_rx.sv
// 8N1 oversampling UART receiver: 2-FF input synchronizer, mid-bit sampling,
// and registered byte/status outputs for the memory-mapped IO block.
module uart_rx #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DIV        = CLK_HZ / (BAUD * OVERSAMPLE)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rxd_data,
    output logic       rxd_done,
    output logic       rxd_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_sync1;
    logic          r_sync2;
    logic [TW-1:0] r_tick;
    logic [SW-1:0] r_samp;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;

    logic w_rxd_s;
    logic w_tick;
    logic w_mid;
    logic w_full;
    logic w_start;
    logic w_shift;
    logic w_accept;
    logic w_ferr;
    logic w_busy;

    assign w_rxd_s = r_sync2;
    assign w_tick  = (r_state != IDLE) && (r_tick == TICK_LAST);
    assign w_mid   = w_tick && (r_samp == SAMP_MID);
    assign w_full  = w_tick && (r_samp == SAMP_LAST);
    assign busy    = w_busy;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!w_rxd_s) w_next = START;
            START:   if (w_mid) w_next = w_rxd_s ? IDLE : DATA;
            DATA:    if (w_full && (r_bit == 3'd7)) w_next = STOP;
            STOP:    if (w_full) w_next = w_rxd_s ? IDLE : WAIT_HI;
            WAIT_HI: if (w_rxd_s) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy   = (r_state != IDLE);
        w_start  = (r_state == IDLE) && !w_rxd_s;
        w_shift  = (r_state == DATA) && w_full;
        w_accept = (r_state == STOP) && w_full && w_rxd_s;
        w_ferr   = (r_state == STOP) && w_full && !w_rxd_s;
    end

    // Tick counter keeps running across START->DATA->STOP, so every later
    // sample stays a whole number of bit periods after the start-bit centre.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_tick  <= '0;
            r_samp  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;

            if (r_state == IDLE || r_tick == TICK_LAST) r_tick <= '0;
            else                                        r_tick <= r_tick + 1'b1;

            if (w_next != r_state)   r_samp <= '0;
            else if (w_tick)         r_samp <= (r_samp == SAMP_LAST) ? '0 : r_samp + 1'b1;

            if (r_state != DATA)     r_bit <= '0;
            else if (w_shift)        r_bit <= r_bit + 1'b1;

            if (w_shift) r_shift <= {w_rxd_s, r_shift[7:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_data  <= '0;
            rxd_done  <= 1'b0;
            rxd_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rxd_valid <= w_accept;
            if (w_start) rxd_done <= 1'b0;
            if (w_accept) begin
                rxd_data  <= r_shift;
                rxd_done  <= 1'b1;
                frame_err <= 1'b0;
            end
            if (w_ferr) frame_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with DIV=4, OVERSAMPLE=16: 64 cycles per bit,
// stop-bit sample 611 cycles after the pin's falling start edge.
module tb_uart_rx;
    localparam int OS  = 16;
    localparam int DV  = 4;
    localparam int BIT = OS * DV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b0;
    logic [7:0] rxd_data;
    logic       rxd_done;
    logic       rxd_valid;
    logic       frame_err;
    logic       busy;

    int cyc     = 0;
    int n_vec   = 0;
    int n_bad   = 0;
    int n_valid = 0;

    uart_rx #(
        .CLK_HZ    (50_000_000),
        .BAUD      (115200),
        .OVERSAMPLE(OS),
        .DIV       (DV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .rxd_data (rxd_data),
        .rxd_done (rxd_done),
        .rxd_valid(rxd_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rxd_valid === 1'b1) n_valid++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected summary");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Park on the negedge that follows posedge number c.
    task automatic wait_neg(input int c);
        do @(negedge clk); while (cyc < c);
        if (cyc != c) chk("late", cyc, c);
    endtask

    // Drive frame bits LSB first, one bit per BIT cycles, for ncyc cycles.
    task automatic drive_line(input logic [9:0] fr, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            rxd = fr[c / BIT];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic align(output int n);
        @(posedge clk);
        #1;
        n = cyc;
    endtask

    initial begin
        int n;
        int v0;

        // reset held with line low
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) chk("rst_hold", {rxd_data, rxd_done, rxd_valid, frame_err, busy}, 0);
        end
        rxd = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(posedge clk);

        // clean byte 0xA5
        align(n);
        v0 = n_valid;
        fork
            drive_line({1'b1, 8'hA5, 1'b0}, 10 * BIT);
            begin
                wait_neg(n + 2);   chk("clean_busy_pre", busy, 0);
                wait_neg(n + 3);   chk("clean_busy_rise", busy, 1);
                wait_neg(n + 610); chk("clean_valid_early", rxd_valid, 0);
                                   chk("clean_busy_hold", busy, 1);
                wait_neg(n + 611); chk("clean_valid", rxd_valid, 1);
                                   chk("clean_data", rxd_data, 8'hA5);
                                   chk("clean_done", rxd_done, 1);
                                   chk("clean_ferr", frame_err, 0);
                                   chk("clean_busy_fall", busy, 0);
                wait_neg(n + 612); chk("clean_valid_pulse", rxd_valid, 0);
                                   chk("clean_done_hold", rxd_done, 1);
            end
        join
        repeat (20) @(posedge clk);
        chk("clean_npulse", n_valid - v0, 1);

        // glitch: 12 cycles low
        align(n);
        v0 = n_valid;
        fork
            begin
                rxd = 1'b0;
                repeat (12) @(posedge clk);
                #1 rxd = 1'b1;
            end
            begin
                wait_neg(n + 3);  chk("glitch_done_clr", rxd_done, 0);
                                  chk("glitch_busy", busy, 1);
                wait_neg(n + 34); chk("glitch_busy_hold", busy, 1);
                wait_neg(n + 35); chk("glitch_idle", busy, 0);
                                  chk("glitch_data", rxd_data, 8'hA5);
                                  chk("glitch_done", rxd_done, 0);
            end
        join
        repeat (100) @(posedge clk);
        chk("glitch_npulse", n_valid - v0, 0);

        // framing error on 0x3C, line held low 200 more cycles
        align(n);
        v0 = n_valid;
        fork
            begin
                drive_line({1'b0, 8'h3C, 1'b0}, 10 * BIT);
                repeat (200) @(posedge clk);
                #1 rxd = 1'b1;
            end
            begin
                wait_neg(n + 611); chk("ferr_set", frame_err, 1);
                                   chk("ferr_data", rxd_data, 8'hA5);
                                   chk("ferr_valid", rxd_valid, 0);
                                   chk("ferr_busy", busy, 1);
                                   chk("ferr_done", rxd_done, 0);
                wait_neg(n + 842); chk("ferr_wait_hi", busy, 1);
                wait_neg(n + 843); chk("ferr_release", busy, 0);
                                   chk("ferr_keep", frame_err, 1);
            end
        join
        repeat (20) @(posedge clk);
        chk("ferr_npulse", n_valid - v0, 0);

        // back-to-back 0x00 then 0xFF
        align(n);
        v0 = n_valid;
        fork
            begin
                drive_line({1'b1, 8'h00, 1'b0}, 10 * BIT);
                drive_line({1'b1, 8'hFF, 1'b0}, 10 * BIT);
                rxd = 1'b1;
            end
            begin
                wait_neg(n + 611);  chk("b2b_valid0", rxd_valid, 1);
                                    chk("b2b_data0", rxd_data, 8'h00);
                                    chk("b2b_done0", rxd_done, 1);
                                    chk("b2b_ferr_clr", frame_err, 0);
                wait_neg(n + 642);  chk("b2b_done_hold", rxd_done, 1);
                wait_neg(n + 643);  chk("b2b_done_drop", rxd_done, 0);
                                    chk("b2b_busy2", busy, 1);
                wait_neg(n + 1250); chk("b2b_valid1_early", rxd_valid, 0);
                                    chk("b2b_done_low", rxd_done, 0);
                wait_neg(n + 1251); chk("b2b_valid1", rxd_valid, 1);
                                    chk("b2b_data1", rxd_data, 8'hFF);
                                    chk("b2b_done1", rxd_done, 1);
            end
        join
        repeat (20) @(posedge clk);
        chk("b2b_npulse", n_valid - v0, 2);

        // reset during data bit 4 of 0x81, line then idle
        align(n);
        v0 = n_valid;
        drive_line({1'b1, 8'h81, 1'b0}, 349);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        rxd = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_outs", {rxd_data, rxd_done, rxd_valid, frame_err, busy}, 0);
        repeat (700) @(posedge clk);
        #1;
        chk("mid_quiet_outs", {rxd_data, rxd_done, rxd_valid, frame_err, busy}, 0);
        chk("mid_npulse", n_valid - v0, 0);

        // clean byte 0x5A after the reset
        align(n);
        v0 = n_valid;
        fork
            drive_line({1'b1, 8'h5A, 1'b0}, 10 * BIT);
            begin
                wait_neg(n + 611); chk("post_valid", rxd_valid, 1);
                                   chk("post_data", rxd_data, 8'h5A);
                                   chk("post_done", rxd_done, 1);
                                   chk("post_ferr", frame_err, 0);
            end
        join
        repeat (20) @(posedge clk);
        chk("post_npulse", n_valid - v0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
